// File: rtl/light_phase_timer_if.sv
// Phase-timer bus between phase controller and timer.
// Carries bcd_tens/bcd_ones only when LIGHT_TIMER_BCD_EN is defined.
interface light_phase_timer_if #(
  parameter int pCount_width = 5
);
  logic                    en;
  logic                    ctr_load;
  logic [pCount_width-1:0] load_count;
  logic                    light_tick;
  logic                    sec_tick;
  logic [pCount_width-1:0] count_remaining;
`ifdef LIGHT_TIMER_BCD_EN
  logic [3:0]              bcd_tens;
  logic [3:0]              bcd_ones;
`endif

  modport master (
    output en,
    output ctr_load,
    output load_count,
    input  light_tick,
    input  sec_tick,
    input  count_remaining
`ifdef LIGHT_TIMER_BCD_EN
    ,
    input  bcd_tens,
    input  bcd_ones
`endif
  );

  modport slave (
    input  en,
    input  ctr_load,
    input  load_count,
    output light_tick,
    output sec_tick,
    output count_remaining
`ifdef LIGHT_TIMER_BCD_EN
    ,
    output bcd_tens,
    output bcd_ones
`endif
  );
endinterface

// File: rtl/light_phase_timer.sv
// Per-phase seconds countdown with a one-second prescaler.
// Optional BCD digit outputs under macro LIGHT_TIMER_BCD_EN.
module light_phase_timer #(
  parameter int pClk_Per_Sec = 50000000,
  parameter int pCount_width = 5
) (
  input  logic              clk,
  input  logic              rstb,
  light_phase_timer_if.slave bus
);
  localparam int PW = $clog2(pClk_Per_Sec);
  localparam logic [PW-1:0] PMAX = PW'(pClk_Per_Sec - 1);

  logic [PW-1:0]           pre_cnt;
  logic [pCount_width-1:0] count;
  logic                    sec_tick;
  logic                    zero;

  // pre_cnt is 0 in reset, so sec_tick is low there too
  assign sec_tick = bus.en & (pre_cnt == PMAX);
  assign zero     = (count == '0);

  assign bus.sec_tick        = sec_tick;
  assign bus.light_tick      = sec_tick & zero;
  assign bus.count_remaining = count;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (bus.en) begin
      if (bus.ctr_load) begin
        pre_cnt <= '0;
        count   <= bus.load_count;
      end else begin
        if (sec_tick) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
        if (sec_tick && !zero) begin
          count <= count - 1'b1;
        end
      end
    end
  end

`ifdef LIGHT_TIMER_BCD_EN
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;

  assign bus.bcd_tens = bcd_tens;
  assign bus.bcd_ones = bcd_ones;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bcd_tens <= '0;
      bcd_ones <= '0;
    end else if (bus.en) begin
      bcd_tens <= 4'(count / 10);
      bcd_ones <= 4'(count % 10);
    end
  end
`endif

endmodule

// File: tb/tb_light_phase_timer.sv
// Bench for light_phase_timer: per-cycle model compare plus
// directed literal checks of the phase timing scenarios.
module tb_light_phase_timer;
  localparam int P  = 4;
  localparam int CW = 5;

  logic clk;
  logic rstb;

  light_phase_timer_if #(.pCount_width(CW)) bus ();

  light_phase_timer #(
    .pClk_Per_Sec(P),
    .pCount_width(CW)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  bit mon_on  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase = loaded seconds N plus enabled cycles elapsed since load.
  int m_n = 0;
  int m_e = 0;
  int m_tens = 0;
  int m_ones = 0;

  function automatic int exp_count();
    int r;
    r = m_n - m_e / P;
    return (r > 0) ? r : 0;
  endfunction

  function automatic int exp_sec();
    return (bus.en && (m_e % P == P - 1)) ? 1 : 0;
  endfunction

  function automatic int exp_light();
    return (exp_sec() == 1 && exp_count() == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_n = 0;
      m_e = 0;
      m_tens = 0;
      m_ones = 0;
    end else if (bus.en) begin
      m_tens = exp_count() / 10;
      m_ones = exp_count() % 10;
      if (bus.ctr_load) begin
        m_n = int'(bus.load_count);
        m_e = 0;
      end else begin
        m_e++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_count", int'(bus.count_remaining), exp_count());
      chk("mon_sec", int'(bus.sec_tick), exp_sec());
      chk("mon_light", int'(bus.light_tick), exp_light());
`ifdef LIGHT_TIMER_BCD_EN
      chk("mon_tens", int'(bus.bcd_tens), m_tens);
      chk("mon_ones", int'(bus.bcd_ones), m_ones);
`endif
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int v);
    bus.ctr_load   = 1'b1;
    bus.load_count = CW'(v);
    cyc();
    bus.ctr_load   = 1'b0;
  endtask

  initial begin
    rstb           = 1'b0;
    bus.en         = 1'b0;
    bus.ctr_load   = 1'b0;
    bus.load_count = '0;
    mon_on         = 1'b1;
    cyc(2);
    chk("rst_count", int'(bus.count_remaining), 0);
    chk("rst_light", int'(bus.light_tick), 0);

    // first tick after release, no load
    rstb   = 1'b1;
    bus.en = 1'b1;
    cyc(2);
    chk("boot_light_early", int'(bus.light_tick), 0);
    cyc();
    chk("boot_light", int'(bus.light_tick), 1);
    chk("boot_sec", int'(bus.sec_tick), 1);

    // load 2: three seconds; later load_count changes ignored
    load(2);
    bus.load_count = CW'(9);
    for (int k = 1; k <= 12; k++) begin
      chk("l2_light", int'(bus.light_tick), (k == 12) ? 1 : 0);
      chk("l2_count", int'(bus.count_remaining),
          (k <= 4) ? 2 : (k <= 8) ? 1 : 0);
      if (k < 12) cyc();
    end

    // load 0: tick every second, saturated at 0
    load(0);
    for (int k = 1; k <= 12; k++) begin
      chk("l0_light", int'(bus.light_tick), (k % 4 == 0) ? 1 : 0);
      chk("l0_count", int'(bus.count_remaining), 0);
      if (k < 12) cyc();
    end

    // load 3 with a 7-cycle freeze starting in cycle 3
    load(3);
    cyc(2);
    bus.en = 1'b0;
    for (int k = 3; k <= 9; k++) begin
      chk("frz_sec", int'(bus.sec_tick), 0);
      chk("frz_count", int'(bus.count_remaining), 3);
      cyc();
    end
    bus.en = 1'b1;
    for (int k = 10; k <= 23; k++) begin
      chk("frz_light", int'(bus.light_tick), (k == 23) ? 1 : 0);
      if (k < 23) cyc();
    end

    // load coinciding with sec_tick at count 5
    load(5);
    cyc(3);
    chk("pri_sec", int'(bus.sec_tick), 1);
    chk("pri_count5", int'(bus.count_remaining), 5);
    bus.ctr_load   = 1'b1;
    bus.load_count = CW'(9);
    cyc();
    bus.ctr_load   = 1'b0;
    chk("pri_count9", int'(bus.count_remaining), 9);
    cyc(2);
    chk("pri_sec_early", int'(bus.sec_tick), 0);
    cyc();
    chk("pri_sec_next", int'(bus.sec_tick), 1);
    chk("pri_hold9", int'(bus.count_remaining), 9);

`ifdef LIGHT_TIMER_BCD_EN
    load(17);
    chk("bcd_count17", int'(bus.count_remaining), 17);
    cyc();
    chk("bcd_tens17", int'(bus.bcd_tens), 1);
    chk("bcd_ones17", int'(bus.bcd_ones), 7);
    cyc(3);
    chk("bcd_count16", int'(bus.count_remaining), 16);
    chk("bcd_ones_lag", int'(bus.bcd_ones), 7);
    cyc();
    chk("bcd_tens16", int'(bus.bcd_tens), 1);
    chk("bcd_ones16", int'(bus.bcd_ones), 6);
`endif

    // asynchronous reset mid-count while sec_tick is high
    load(7);
    cyc(3);
    chk("mid_sec", int'(bus.sec_tick), 1);
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_count", int'(bus.count_remaining), 0);
    chk("mid_rst_sec", int'(bus.sec_tick), 0);
    chk("mid_rst_light", int'(bus.light_tick), 0);
`ifdef LIGHT_TIMER_BCD_EN
    chk("mid_rst_tens", int'(bus.bcd_tens), 0);
    chk("mid_rst_ones", int'(bus.bcd_ones), 0);
`endif
    cyc(2);
    rstb = 1'b1;
    cyc(3);
    chk("rel_light", int'(bus.light_tick), 1);
    cyc(4);
    chk("rel_light_rep", int'(bus.light_tick), 1);

    // random loads and enables, model-checked every cycle
    for (int i = 0; i < 300; i++) begin
      bus.en         = ($urandom_range(0, 7) != 0);
      bus.ctr_load   = ($urandom_range(0, 19) == 0);
      bus.load_count = CW'($urandom_range(0, 20));
      cyc();
    end
    bus.ctr_load = 1'b0;
    cyc(2);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
